// File: rtl/fir_pkg.sv
// Shared constants, types and loader states for the 41-tap FIR filter and its
// coefficient loader.
package fir_pkg;
  localparam int FIR_NUM_TAPS = 41;
  localparam int FIR_COEFF_W  = 16;
  localparam int FIR_SEL_W    = 6;

  typedef logic [FIR_COEFF_W-1:0] fir_coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } loader_state_t;
endpackage

// File: rtl/fir_coeff_loader.sv
// Streams one coefficient set into the FIR tap write port and flags length errors.
// Defining FIR_COEFF_LOADER_CHECKSUM_EN adds a running checksum output.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | writing one tap per accepted beat
// DRAIN | set too long; discarding beats up to s_last
// DONE  | one-cycle completion pulse
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int COEFF_W  = FIR_COEFF_W,
  parameter int SEL_W    = FIR_SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COEFF_W-1:0] s_data,
  input  logic               s_last,
  output logic               coeff_update,
  output logic [SEL_W-1:0]   coeff_sel,
  output logic [COEFF_W-1:0] new_coeff,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SEL_W-1:0]   tap_count
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
  ,
  output logic [COEFF_W-1:0] checksum
`endif
);

  loader_state_t      r_state;
  loader_state_t      w_next;
  logic [SEL_W-1:0]   r_index;
  logic [SEL_W-1:0]   r_tap_count;
  logic               r_err;
  logic               r_update;
  logic [SEL_W-1:0]   r_sel;
  logic [COEFF_W-1:0] r_coeff;
  logic               w_accept;
  logic               w_write;
  logic               w_at_last;
  logic               w_start;

  assign s_ready   = (r_state == LOAD) || (r_state == DRAIN);
  assign w_accept  = s_valid && s_ready;
  assign w_write   = w_accept && (r_state == LOAD);
  assign w_at_last = (r_index == SEL_W'(NUM_TAPS - 1));
  assign w_start   = start && (r_state == IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD: begin
        if (w_accept) begin
          if (s_last)         w_next = DONE;
          else if (w_at_last) w_next = DRAIN;
        end
      end
      DRAIN:   if (w_accept && s_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_index     <= '0;
      r_tap_count <= '0;
      r_err       <= 1'b0;
      r_update    <= 1'b0;
      r_sel       <= '0;
      r_coeff     <= '0;
    end else begin
      r_state  <= w_next;
      r_update <= 1'b0;
      if (w_start) begin
        r_index     <= '0;
        r_tap_count <= '0;
        r_err       <= 1'b0;
      end
      // the last tap index is held so an overlong set can never wrap onto tap 0
      if (w_write) begin
        r_update    <= 1'b1;
        r_sel       <= r_index;
        r_coeff     <= s_data;
        r_tap_count <= r_tap_count + SEL_W'(1);
        if (!w_at_last) r_index <= r_index + SEL_W'(1);
        if (w_at_last)   r_err <= !s_last;
        else if (s_last) r_err <= 1'b1;
      end
    end
  end

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
  logic [COEFF_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset)        r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_write) r_checksum <= r_checksum + s_data;
  end

  assign checksum = r_checksum;
`endif

  assign coeff_update = r_update;
  assign coeff_sel    = r_sel;
  assign new_coeff    = r_coeff;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign err          = r_err;
  assign tap_count    = r_tap_count;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: table of coefficient-set loads plus
// hand sequences for reset mid-load and the power-up state.
module tb_fir_coeff_loader;
  localparam int NT = 41;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_ready, s_last;
  logic [15:0] s_data, new_coeff;
  logic        coeff_update, busy, done, err;
  logic [5:0]  coeff_sel, tap_count;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  fir_coeff_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .coeff_update (coeff_update),
    .coeff_sel    (coeff_sel),
    .new_coeff    (new_coeff),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .tap_count    (tap_count)
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int nbeats;
    int gap;
    int mode;
    int base;
    int inj_start;
  } vec_t;

  typedef struct {
    int sel;
    int data;
    int dn;
    int cy;
  } wr_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_ready = 0;
  wr_t  wq[$];
  int   acc_cyc[64];
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (coeff_update) wq.push_back('{int'(coeff_sel), int'(new_coeff), int'(done), cyc});
    if (done) begin
      done_cnt   = done_cnt + 1;
      done_ready = int'(s_ready);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] dval(input int mode, input int base, input int i);
    if (mode == 0) return 16'(base + i);
    if (i == 0) return 16'hFFFF;
    if (i == 1) return 16'h0002;
    return 16'h0000;
  endfunction

  task automatic run_load(input int vi, input vec_t v);
    int          b, j, k, n_w, exp_dn;
    bit          inj, acc, ready_bad;
    logic [15:0] cs;
    string       p;
    p = $sformatf("v%0d", vi);
    b = 0; j = 0; inj = 0; ready_bad = 0;
    wq.delete();
    done_cnt = 0;
    done_ready = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (b < v.nbeats && j < 1000) begin
      if (v.inj_start != 0 && b == 5 && !inj) begin
        start = 1'b1; s_valid = 1'b0; inj = 1'b1;
      end else begin
        start = 1'b0;
        s_valid = (v.gap == 0) || (j % 3 == 0);
      end
      s_data = dval(v.mode, v.base, b);
      s_last = (b == v.nbeats - 1);
      @(negedge clk);
      if (!s_ready) ready_bad = 1'b1;
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[b] = cyc;
        b++;
      end
      j++;
    end
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check({p, " beats_accepted"}, b, v.nbeats);
    k = 0;
    while (done_cnt == 0 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    n_w = (v.nbeats > NT) ? NT : v.nbeats;
    check({p, " ready_in_load"}, int'(ready_bad), 0);
    check({p, " done_pulses"}, done_cnt, 1);
    check({p, " ready_in_done"}, done_ready, 0);
    check({p, " busy_after"}, int'(busy), 0);
    check({p, " err"}, int'(err), (v.nbeats != NT) ? 1 : 0);
    check({p, " tap_count"}, int'(tap_count), n_w);
    check({p, " n_writes"}, wq.size(), n_w);
    cs = 16'h0;
    for (int i = 0; i < n_w; i++) begin
      cs = cs + dval(v.mode, v.base, i);
      if (i < wq.size()) begin
        exp_dn = (i == n_w - 1 && v.nbeats <= NT) ? 1 : 0;
        check($sformatf("%s w%0d sel", p, i), wq[i].sel, i);
        check($sformatf("%s w%0d data", p, i), wq[i].data, int'(dval(v.mode, v.base, i)));
        check($sformatf("%s w%0d cycle", p, i), wq[i].cy, acc_cyc[i]);
        check($sformatf("%s w%0d done", p, i), wq[i].dn, exp_dn);
      end
    end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    check({p, " checksum"}, int'(checksum), int'(cs));
`endif
  endtask

  initial begin
    int  b, k;
    bit  acc;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst s_ready", int'(s_ready), 0);
    check("rst coeff_update", int'(coeff_update), 0);
    check("rst coeff_sel", int'(coeff_sel), 0);
    check("rst new_coeff", int'(new_coeff), 0);
    check("rst err", int'(err), 0);
    check("rst tap_count", int'(tap_count), 0);

    vecs[0] = '{41, 0, 0, 1, 0};
    vecs[1] = '{41, 1, 0, 1, 0};
    vecs[2] = '{10, 0, 0, 1, 0};
    vecs[3] = '{45, 0, 0, 100, 0};
    vecs[4] = '{1, 0, 0, 16'h7777, 0};
    vecs[5] = '{41, 0, 0, 16'h0200, 1};
    vecs[6] = '{41, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      run_load(i, vecs[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // reset in the middle of a load
    wq.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = 0; k = 0;
    while (b < 20 && k < 100) begin
      s_valid = 1'b1; s_data = 16'(b + 50); s_last = 1'b0;
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) b++;
      k++;
    end
    s_valid = 1'b0;
    check("mid tap_count", int'(tap_count), 20);
    check("mid busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid rst busy", int'(busy), 0);
    check("mid rst s_ready", int'(s_ready), 0);
    check("mid rst coeff_update", int'(coeff_update), 0);
    check("mid rst tap_count", int'(tap_count), 0);
    check("mid rst done", int'(done), 0);
    check("mid writes", wq.size(), 20);

    run_load(7, vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
